spike_rate_decoder: RTL



---
 rtl/snn_pkg.sv | 22 ++
 rtl/spike_argmax.sv | 38 +++
 rtl/spike_rate_decoder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the SNN output-layer blocks: default sizes,
// decoder state encoding and a saturating increment helper.
package snn_pkg;

  localparam int SNN_NUM_OUT    = 2;
  localparam int SNN_DEC_WINDOW = 256;
  localparam int SNN_CNT_W      = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } dec_state_e;

  // Adds one when inc is set, but never past max_val.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic        inc,
                                          input logic [31:0] max_val);
    if (inc && (val < max_val)) return val + 32'd1;
    return val;
  endfunction

endpackage

// File: rtl/spike_argmax.sv
// Combinational argmax over per-channel spike counts; equal counts resolve
// to the lowest channel index.
module spike_argmax
  import snn_pkg::*;
#(
  parameter int NUM_CH = SNN_NUM_OUT,
  parameter int CNT_W  = SNN_CNT_W
) (
  input  logic [NUM_CH-1:0][CNT_W-1:0]  counts,
  output logic [$clog2(NUM_CH)-1:0]     winner,
  output logic                          tie,
  output logic                          no_spike
);

  localparam int IDX_W = $clog2(NUM_CH);

  logic [CNT_W-1:0] best;
  logic [3:0]       n_eq;

  always_comb begin
    best   = counts[0];
    winner = '0;
    for (int i = 1; i < NUM_CH; i++) begin
      if (counts[i] > best) begin
        best   = counts[i];
        winner = IDX_W'(i);
      end
    end
    // An all-zero vector counts as a tie since every channel matches.
    n_eq = 4'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (counts[i] == best) n_eq = n_eq + 4'd1;
    end
    tie      = (n_eq > 4'd1);
    no_spike = (best == '0);
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike-rate decoder: counts spikes per channel over WINDOW cycles
// and publishes counts plus the winning class on a valid/ready interface.
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int NUM_CH = SNN_NUM_OUT,
  parameter int WINDOW = SNN_DEC_WINDOW,
  parameter int CNT_W  = SNN_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clear,
  input  logic [NUM_CH-1:0]          spikes_in,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [NUM_CH*CNT_W-1:0]    count_out,
  output logic [$clog2(NUM_CH)-1:0]  winner,
  output logic                       tie,
  output logic                       no_spike,
  output logic                       overrun,
  output logic                       busy
);

  localparam int              IDX_W    = $clog2(NUM_CH);
  localparam int              WCW      = $clog2(WINDOW);
  localparam logic [WCW-1:0]  WIN_LAST = WCW'(WINDOW - 1);
  localparam logic [31:0]     CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);

  dec_state_e                      state_q, state_d;
  logic [NUM_CH-1:0][CNT_W-1:0]    acc_q, acc_d, acc_inc;
  logic [WCW-1:0]                  win_cnt_q, win_cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0]    snap_q, snap_d;
  logic                            snap_vld_q, snap_vld_d;
  logic [NUM_CH*CNT_W-1:0]         count_out_q, count_out_d;
  logic [IDX_W-1:0]                winner_q, winner_d;
  logic                            tie_q, tie_d;
  logic                            no_spike_q, no_spike_d;
  logic                            out_valid_q, out_valid_d;
  logic                            overrun_q, overrun_d;

  logic [IDX_W-1:0]                am_winner;
  logic                            am_tie;
  logic                            am_no_spike;

  spike_argmax #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) u_argmax (
    .counts   (snap_q),
    .winner   (am_winner),
    .tie      (am_tie),
    .no_spike (am_no_spike)
  );

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      acc_inc[i] = CNT_W'(sat_inc(32'(acc_q[i]), spikes_in[i], CNT_MAX));
    end

    state_d     = state_q;
    acc_d       = acc_q;
    win_cnt_d   = win_cnt_q;
    snap_d      = snap_q;
    snap_vld_d  = 1'b0;
    count_out_d = count_out_q;
    winner_d    = winner_q;
    tie_d       = tie_q;
    no_spike_d  = no_spike_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    if (clear) begin
      state_d     = IDLE;
      acc_d       = '0;
      win_cnt_d   = '0;
      snap_d      = '0;
      count_out_d = '0;
      winner_d    = '0;
      tie_d       = 1'b0;
      no_spike_d  = 1'b0;
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) state_d = ACCUM;
        end
        ACCUM: begin
          if (!en) begin
            state_d   = IDLE;
            acc_d     = '0;
            win_cnt_d = '0;
          end else if (win_cnt_q == WIN_LAST) begin
            snap_d     = acc_inc;
            snap_vld_d = 1'b1;
            acc_d      = '0;
            win_cnt_d  = '0;
          end else begin
            acc_d     = acc_inc;
            win_cnt_d = win_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      // A fresh snapshot replaces the held result even under backpressure.
      if (snap_vld_q) begin
        count_out_d = snap_q;
        winner_d    = am_winner;
        tie_d       = am_tie;
        no_spike_d  = am_no_spike;
        out_valid_d = 1'b1;
        if (out_valid_q && !out_ready) overrun_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      win_cnt_q   <= '0;
      snap_q      <= '0;
      snap_vld_q  <= 1'b0;
      count_out_q <= '0;
      winner_q    <= '0;
      tie_q       <= 1'b0;
      no_spike_q  <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      win_cnt_q   <= win_cnt_d;
      snap_q      <= snap_d;
      snap_vld_q  <= snap_vld_d;
      count_out_q <= count_out_d;
      winner_q    <= winner_d;
      tie_q       <= tie_d;
      no_spike_q  <= no_spike_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign count_out = count_out_q;
  assign winner    = winner_q;
  assign tie       = tie_q;
  assign no_spike  = no_spike_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == ACCUM);

endmodule
